matmul_stream: RTL and testbench

MATMUL_STREAM -- requirements
Module: matmul_stream

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/mac_unit.sv | 46 ++++
 rtl/matmul_stream.sv | 191 +++++++++++++++++++
 tb/tb_matmul_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding, default dimensions and index-width helper
package matmul_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_M  = 3;
   localparam int DEF_K  = 4;
   localparam int DEF_N  = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      COMPUTE = 3'd3,
      OUTPUT  = 3'd4,
      FINISH  = 3'd5
   } state_t;

   // Index registers keep at least one bit so single-entry dimensions still have a counter.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed/unsigned multiply-accumulate with clear and enable
module mac_unit #(
   parameter int DW = 8,
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   input  logic          mode_signed,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [AW-1:0] acc
);

   logic [2*DW-1:0] a_ext;
   logic [2*DW-1:0] b_ext;
   logic [2*DW-1:0] prod;
   logic [AW-1:0]   prod_ext;

   // Extending both operands to 2*DW before a same-width multiply gives the exact
   // signed or unsigned product in the low 2*DW bits with one multiplier.
   always_comb begin
      a_ext = mode_signed ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
      b_ext = mode_signed ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
      prod  = a_ext * b_ext;
   end

   generate
      if (AW > 2*DW) begin : g_extend
         assign prod_ext = {{(AW-2*DW){mode_signed & prod[2*DW-1]}}, prod};
      end else begin : g_fit
         assign prod_ext = prod[AW-1:0];
      end
   endgenerate

   // Accumulate modulo 2^AW; clear wins over enable so a new element always starts at zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/matmul_stream.sv
// rtl/matmul_stream.sv - streaming matrix multiplier C = A x B with handshaked input and output
module matmul_stream
   import matmul_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int M  = DEF_M,
   parameter int K  = DEF_K,
   parameter int N  = DEF_N,
   parameter int AW = 2*DW + $clog2(K)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode_signed,
   input  logic          in_valid,
   input  logic [DW-1:0] data_in,
   output logic          in_ready,
   output logic          out_valid,
   output logic [AW-1:0] data_out,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   localparam int IW = idx_w(M);
   localparam int KW = idx_w(K);
   localparam int JW = idx_w(N);

   localparam logic [IW-1:0] I_LAST = IW'(M-1);
   localparam logic [KW-1:0] K_LAST = KW'(K-1);
   localparam logic [JW-1:0] J_LAST = JW'(N-1);

   state_t state;
   state_t state_next;

   logic [IW-1:0] i;
   logic [KW-1:0] k;
   logic [JW-1:0] j;
   logic          mode_q;
   logic          i_last;
   logic          k_last;
   logic          j_last;
   logic          mac_clear;
   logic          mac_en;
   logic [AW-1:0] acc;

   logic [DW-1:0] a_mem [M][K];
   logic [DW-1:0] b_mem [K][N];

   // The same (i,k,j) counters address A and B during loading and walk the MAC during compute.
   always_comb begin
      i_last = (i == I_LAST);
      k_last = (k == K_LAST);
      j_last = (j == J_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs; accumulator clears on every transition into COMPUTE.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      mac_clear  = 1'b0;
      mac_en     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = LOAD_A;
         end
         LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid && i_last && k_last) state_next = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid && k_last && j_last) begin
               state_next = COMPUTE;
               mac_clear  = 1'b1;
            end
         end
         COMPUTE: begin
            mac_en = 1'b1;
            if (k_last) state_next = OUTPUT;
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (i_last && j_last) begin
                  state_next = FINISH;
               end else begin
                  state_next = COMPUTE;
                  mac_clear  = 1'b1;
               end
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Index and mode bookkeeping; loads advance only on accepted elements, outputs on accepted results.
   always_ff @(posedge clk) begin
      if (reset) begin
         i      <= '0;
         k      <= '0;
         j      <= '0;
         mode_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode_signed;
                  i      <= '0;
                  k      <= '0;
                  j      <= '0;
               end
            end
            LOAD_A: begin
               if (in_valid) begin
                  if (k_last) begin
                     k <= '0;
                     i <= i_last ? '0 : i + 1'b1;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  if (j_last) begin
                     j <= '0;
                     k <= k_last ? '0 : k + 1'b1;
                  end else begin
                     j <= j + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               k <= k_last ? '0 : k + 1'b1;
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (j_last) begin
                     j <= '0;
                     i <= i_last ? '0 : i + 1'b1;
                  end else begin
                     j <= j + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Operand storage; no reset needed since every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (!reset && state == LOAD_A && in_valid) a_mem[i][k] <= data_in;
      if (!reset && state == LOAD_B && in_valid) b_mem[k][j] <= data_in;
   end

   mac_unit #(
      .DW (DW),
      .AW (AW)
   ) u_mac (
      .clk         (clk),
      .reset       (reset),
      .clear       (mac_clear),
      .en          (mac_en),
      .mode_signed (mode_q),
      .a           (a_mem[i][k]),
      .b           (b_mem[k][j]),
      .acc         (acc)
   );

   assign data_out = (state == OUTPUT) ? acc : '0;

endmodule

// File: tb/tb_matmul_stream.sv
// tb/tb_matmul_stream.sv - directed and randomized self-checking bench for matmul_stream
module tb_matmul_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode_signed;
   logic        in_valid;
   logic [7:0]  data_in;
   logic        in_ready;
   logic        out_valid;
   logic [17:0] data_out;
   logic        out_ready;
   logic        busy;
   logic        done;

   logic        s_start;
   logic        s_mode;
   logic        s_in_valid;
   logic [7:0]  s_data_in;
   logic        s_in_ready;
   logic        s_out_valid;
   logic [15:0] s_data_out;
   logic        s_out_ready;
   logic        s_busy;
   logic        s_done;

   int checks = 0;
   int errors = 0;

   logic [7:0]  a_arr [12];
   logic [7:0]  b_arr [12];
   logic [17:0] exp_c [9];
   logic [17:0] dir_exp [9] = '{18'd42, 18'd48, 18'd54, 18'd114, 18'd136, 18'd158,
                                18'd186, 18'd224, 18'd262};

   always #5 clk = ~clk;

   matmul_stream dut (
      .clk(clk), .reset(reset), .start(start), .mode_signed(mode_signed),
      .in_valid(in_valid), .data_in(data_in), .in_ready(in_ready),
      .out_valid(out_valid), .data_out(data_out), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   matmul_stream #(.DW(8), .M(1), .K(1), .N(1)) dut1 (
      .clk(clk), .reset(reset), .start(s_start), .mode_signed(s_mode),
      .in_valid(s_in_valid), .data_in(s_data_in), .in_ready(s_in_ready),
      .out_valid(s_out_valid), .data_out(s_data_out), .out_ready(s_out_ready),
      .busy(s_busy), .done(s_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in plain integer arithmetic, kept modulo 2^18.
   function automatic logic [17:0] ref_c(input int ri, input int rj, input bit sgn);
      longint s = 0;
      longint x;
      longint y;
      for (int kk = 0; kk < 4; kk++) begin
         x = sgn ? longint'($signed(a_arr[ri*4+kk])) : longint'(a_arr[ri*4+kk]);
         y = sgn ? longint'($signed(b_arr[kk*3+rj])) : longint'(b_arr[kk*3+rj]);
         s += x * y;
      end
      return s[17:0];
   endfunction

   task automatic fill_directed();
      for (int e = 0; e < 12; e++) begin
         a_arr[e] = 8'(e);
         b_arr[e] = 8'(e);
      end
      for (int e = 0; e < 9; e++) exp_c[e] = dir_exp[e];
   endtask

   task automatic send_elem(input logic [7:0] d, input bit pulse_start);
      int cnt = 0;
      data_in  = d;
      in_valid = 1'b1;
      if (pulse_start) begin
         start       = 1'b1;
         mode_signed = ~mode_signed;
      end
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 20) check("in_ready_timeout", 32'(cnt), 32'd0);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      data_in  = 8'($urandom);
   endtask

   task automatic load_job(input bit sgn, input bit gap, input bit start_in_b);
      int n = 0;
      mode_signed = sgn;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      mode_signed = ~sgn;
      check("load_a_ready", 32'(in_ready), 32'd1);
      check("load_a_busy", 32'(busy), 32'd1);
      for (int e = 0; e < 12; e++) begin
         if (gap && e == 5) begin
            in_valid = 1'b0;
            repeat (3) begin
               data_in = 8'($urandom);
               @(negedge clk);
            end
         end
         send_elem(a_arr[e], 1'b0);
      end
      for (int e = 0; e < 12; e++) send_elem(b_arr[e], start_in_b && e == 3);
      check("compute_not_ready", 32'(in_ready), 32'd0);
      while (!out_valid && n < 50) begin
         in_valid = 1'b1;
         data_in  = 8'($urandom);
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("first_latency", 32'(n + 1), 32'd5);
   endtask

   // ready_mode: 0 always ready, 1 toggling, 2 random. abort_after>0 stops after that many results.
   task automatic collect(input int ready_mode, input int abort_after, input bit check_gap);
      int          idx = 0;
      int          cyc = 0;
      int          last_hs = -1;
      bit          hold_pending = 1'b0;
      logic [17:0] hold_val = '0;
      logic        r;
      while (idx < 9 && cyc < 500) begin
         if (hold_pending) begin
            check("valid_held", 32'(out_valid), 32'd1);
            check("data_stable", 32'(data_out), 32'(hold_val));
         end
         hold_pending = 1'b0;
         check("no_early_done", 32'(done), 32'd0);
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         if (out_valid) begin
            if (r) begin
               check($sformatf("c_elem_%0d", idx), 32'(data_out), 32'(exp_c[idx]));
               if (check_gap && last_hs >= 0) check("elem_spacing", 32'(cyc - last_hs), 32'd5);
               last_hs = cyc;
               idx++;
            end else begin
               hold_pending = 1'b1;
               hold_val     = data_out;
            end
         end
         @(negedge clk);
         cyc++;
         if (abort_after > 0 && idx == abort_after) break;
      end
      out_ready = 1'b0;
      if (abort_after > 0) begin
         check("abort_point", 32'(idx), 32'(abort_after));
      end else begin
         check("all_elems_seen", 32'(idx), 32'd9);
         check("done_pulse", 32'(done), 32'd1);
         @(negedge clk);
         check("done_single", 32'(done), 32'd0);
         check("idle_after", 32'(busy), 32'd0);
      end
   endtask

   task automatic small_job(input bit sgn, input logic [15:0] expv);
      int n = 0;
      s_mode  = sgn;
      s_start = 1'b1;
      @(negedge clk);
      s_start    = 1'b0;
      s_data_in  = 8'hFF;
      s_in_valid = 1'b1;
      check("s_ready_a", 32'(s_in_ready), 32'd1);
      @(negedge clk);
      s_data_in = 8'h02;
      check("s_ready_b", 32'(s_in_ready), 32'd1);
      @(negedge clk);
      s_in_valid = 1'b0;
      while (!s_out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("s_latency", 32'(n + 1), 32'd2);
      check("s_result", 32'(s_data_out), 32'(expv));
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      check("s_done", 32'(s_done), 32'd1);
      @(negedge clk);
      check("s_idle", 32'(s_busy), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      mode_signed = 1'b0;
      in_valid    = 1'b0;
      data_in     = '0;
      out_ready   = 1'b0;
      s_start     = 1'b0;
      s_mode      = 1'b0;
      s_in_valid  = 1'b0;
      s_data_in   = '0;
      s_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_s_busy", 32'(s_busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Defaults, unsigned, always ready.
      fill_directed();
      load_job(1'b0, 1'b0, 1'b0);
      collect(0, 0, 1'b1);

      // Same job with out_ready toggling every cycle.
      load_job(1'b0, 1'b0, 1'b0);
      collect(1, 0, 1'b0);

      // 1x1x1 instance, signed and unsigned interpretation of 0xFF * 0x02.
      small_job(1'b1, 16'hFFFE);
      small_job(1'b0, 16'd510);

      // Input gap in LOAD_A plus a stray start during LOAD_B.
      load_job(1'b0, 1'b1, 1'b1);
      collect(0, 0, 1'b1);

      // Reset while computing C[1][0], then a fresh job.
      load_job(1'b0, 1'b0, 1'b0);
      collect(0, 3, 1'b0);
      check("abort_in_compute", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_data_out", 32'(data_out), 32'd0);
      @(negedge clk);
      check("abort_stays_idle", 32'(busy), 32'd0);
      load_job(1'b0, 1'b0, 1'b0);
      collect(0, 0, 1'b1);

      // Randomized operands and mode against the arithmetic model, random back-pressure.
      for (int t = 0; t < 4; t++) begin
         bit sgn;
         sgn = 1'($urandom_range(0, 1));
         for (int e = 0; e < 12; e++) begin
            a_arr[e] = 8'($urandom);
            b_arr[e] = 8'($urandom);
         end
         for (int ri = 0; ri < 3; ri++)
            for (int rj = 0; rj < 3; rj++)
               exp_c[ri*3+rj] = ref_c(ri, rj, sgn);
         load_job(sgn, 1'b0, 1'b0);
         collect(2, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
